// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: LSU opcodes, writeback select, FSM states
// and the EX/MEM and MEM/WB payload structs.
package mem_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned STRB_W = XLEN / 8;

  typedef enum logic [2:0] {
    LSU_LB  = 3'b000,
    LSU_LH  = 3'b001,
    LSU_LW  = 3'b010,
    LSU_SB  = 3'b011,
    LSU_LBU = 3'b100,
    LSU_LHU = 3'b101,
    LSU_SH  = 3'b110,
    LSU_SW  = 3'b111
  } lsuop_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_RSP  = 2'b10
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]   opr_res;
    logic [XLEN-1:0]   opr_b;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   pc4;
    logic              rf_en;
    logic              dm_en;
    wb_sel_t           wb_sel;
    lsuop_t            lsuop;
  } mem_stage_in_t;

  typedef struct packed {
    logic              valid;
    logic              rf_en;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } mem_stage_out_t;

  function automatic logic lsu_is_store(input lsuop_t op);
    return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational load/store lane logic: alignment check, store strobes/data
// replication and load byte/halfword extraction with sign/zero extension.
module lsu_align
  import mem_stage_pkg::*;
(
  input  lsuop_t             lsuop_i,
  input  logic [1:0]         addr_lo_i,
  input  logic [XLEN-1:0]    st_data_i,
  input  logic [XLEN-1:0]    ld_word_i,
  output logic               aligned_o,
  output logic [STRB_W-1:0]  wstrb_o,
  output logic [XLEN-1:0]    wdata_o,
  output logic [XLEN-1:0]    ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Lane selection from the loaded word
  always_comb begin
    ld_byte = ld_word_i[7:0];
    case (addr_lo_i)
      2'd0:    ld_byte = ld_word_i[7:0];
      2'd1:    ld_byte = ld_word_i[15:8];
      2'd2:    ld_byte = ld_word_i[23:16];
      default: ld_byte = ld_word_i[31:24];
    endcase
    ld_half = addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
  end

  always_comb begin
    aligned_o = 1'b1;
    wstrb_o   = '0;
    wdata_o   = '0;
    ld_data_o = '0;
    case (lsuop_i)
      LSU_LB:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      LSU_LBU: ld_data_o = {24'h0, ld_byte};
      LSU_LH: begin
        aligned_o = ~addr_lo_i[0];
        ld_data_o = {{16{ld_half[15]}}, ld_half};
      end
      LSU_LHU: begin
        aligned_o = ~addr_lo_i[0];
        ld_data_o = {16'h0, ld_half};
      end
      LSU_LW: begin
        aligned_o = (addr_lo_i == 2'b00);
        ld_data_o = ld_word_i;
      end
      LSU_SB: begin
        wstrb_o = STRB_W'(4'b0001 << addr_lo_i);
        wdata_o = {4{st_data_i[7:0]}};
      end
      LSU_SH: begin
        aligned_o = ~addr_lo_i[0];
        wstrb_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o   = {2{st_data_i[15:0]}};
      end
      LSU_SW: begin
        aligned_o = (addr_lo_i == 2'b00);
        wstrb_o   = 4'b1111;
        wdata_o   = st_data_i;
      end
      default: aligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, valid/ready data-memory transaction FSM with
// pipeline stall, MEM/WB result register and forwarding back to execute.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] ex_opr_res,
  input  logic [DATA_WIDTH-1:0] ex_opr_b,
  input  logic [4:0]            ex_rd,
  input  logic [DATA_WIDTH-1:0] ex_pc4,
  input  logic                  ex_rf_en,
  input  logic                  ex_dm_en,
  input  logic [1:0]            ex_wb_sel,
  input  logic [2:0]            ex_lsuop,
  input  logic                  flush,
  output logic                  stall,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic                  dmem_req_we,
  output logic [ADDR_WIDTH-1:0] dmem_req_addr,
  output logic [DATA_WIDTH-1:0] dmem_req_wdata,
  output logic [3:0]            dmem_req_wstrb,
  input  logic                  dmem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] dmem_rsp_rdata,
  output logic                  fwd_rf_en,
  output logic [4:0]            fwd_rd,
  output logic [DATA_WIDTH-1:0] fwd_opr_res,
  output logic                  wb_valid,
  output logic                  wb_rf_en,
  output logic [4:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  misaligned
);

  mem_stage_in_t  m_q, m_d;
  logic           m_valid_q, m_valid_d;
  state_t         state_q, state_d;
  mem_stage_out_t wb_q, wb_d;
  logic           misaligned_q, misaligned_d;

  logic              aligned;
  logic [STRB_W-1:0] lsu_wstrb;
  logic [XLEN-1:0]   lsu_wdata;
  logic [XLEN-1:0]   lsu_ld_data;

  logic is_mem, is_store, mis_c, req_active, hs, done;

  lsu_align u_lsu_align (
    .lsuop_i   (m_q.lsuop),
    .addr_lo_i (m_q.opr_res[1:0]),
    .st_data_i (m_q.opr_b),
    .ld_word_i (dmem_rsp_rdata),
    .aligned_o (aligned),
    .wstrb_o   (lsu_wstrb),
    .wdata_o   (lsu_wdata),
    .ld_data_o (lsu_ld_data)
  );

  // Transaction control; IDLE with a pending access already presents the request
  always_comb begin
    is_mem     = m_valid_q & m_q.dm_en;
    is_store   = lsu_is_store(m_q.lsuop);
    mis_c      = is_mem & ~aligned;
    req_active = is_mem & aligned & (state_q != S_RSP);
    hs         = req_active & dmem_req_ready;
    done       = (hs & is_store) | ((state_q == S_RSP) & dmem_rsp_valid);
    stall      = is_mem & aligned & ~done;

    state_d = state_q;
    case (state_q)
      S_IDLE, S_REQ: begin
        if (!req_active)  state_d = S_IDLE;
        else if (!hs)     state_d = S_REQ;
        else if (is_store) state_d = S_IDLE;
        else              state_d = S_RSP;
      end
      S_RSP:   if (dmem_rsp_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // EX/MEM capture (held while stalled) and MEM/WB result selection
  always_comb begin
    m_d       = m_q;
    m_valid_d = m_valid_q;
    if (!stall) begin
      m_d.opr_res = ex_opr_res;
      m_d.opr_b   = ex_opr_b;
      m_d.rd      = ex_rd;
      m_d.pc4     = ex_pc4;
      m_d.rf_en   = ex_rf_en;
      m_d.dm_en   = ex_dm_en;
      m_d.wb_sel  = wb_sel_t'(ex_wb_sel);
      m_d.lsuop   = lsuop_t'(ex_lsuop);
      m_valid_d   = ~flush;
    end

    wb_d.valid = m_valid_q & ~stall;
    wb_d.rf_en = wb_d.valid & m_q.rf_en & ~mis_c;
    wb_d.rd    = m_q.rd;
    case (m_q.wb_sel)
      WB_ALU:  wb_d.data = m_q.opr_res;
      WB_MEM:  wb_d.data = lsu_ld_data;
      WB_PC4:  wb_d.data = m_q.pc4;
      default: wb_d.data = '0;
    endcase
    misaligned_d = mis_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q          <= '0;
      m_valid_q    <= 1'b0;
      state_q      <= S_IDLE;
      wb_q         <= '0;
      misaligned_q <= 1'b0;
    end else begin
      m_q          <= m_d;
      m_valid_q    <= m_valid_d;
      state_q      <= state_d;
      wb_q         <= wb_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign dmem_req_valid = req_active;
  assign dmem_req_we    = req_active & is_store;
  assign dmem_req_addr  = req_active ? ADDR_WIDTH'({m_q.opr_res[XLEN-1:2], 2'b00}) : '0;
  assign dmem_req_wdata = (req_active & is_store) ? lsu_wdata : '0;
  assign dmem_req_wstrb = (req_active & is_store) ? lsu_wstrb : '0;

  // Load data is not available in MEM, so only ALU results are forwarded
  assign fwd_rf_en   = m_valid_q & m_q.rf_en & (m_q.wb_sel == WB_ALU);
  assign fwd_rd      = m_q.rd;
  assign fwd_opr_res = m_q.opr_res;

  assign wb_valid   = wb_q.valid;
  assign wb_rf_en   = wb_q.rf_en;
  assign wb_rd      = wb_q.rd;
  assign wb_data    = wb_q.data;
  assign misaligned = misaligned_q;

endmodule
